// File: rtl/logic_basic_queue_pkg.sv
// rtl/logic_basic_queue_pkg.sv - shared sizing helpers for the generic queue controllers
package logic_basic_queue_pkg;

  // Number of entries addressed by an ADDRESS_WIDTH-bit pointer.
  function automatic int queue_capacity(input int address_width);
    return 2 ** address_width;
  endfunction

  // Occupancy needs one extra bit so that a full queue (CAPACITY) is representable.
  function automatic int count_width(input int address_width);
    return address_width + 1;
  endfunction

  // Default almost-full threshold: one entry short of full.
  function automatic int default_almost_full(input int address_width);
    return queue_capacity(address_width) - 1;
  endfunction

endpackage

// File: rtl/logic_basic_queue_generic_write.sv
// rtl/logic_basic_queue_generic_write.sv - write-side controller and occupancy owner of the generic queue
module logic_basic_queue_generic_write
  import logic_basic_queue_pkg::*;
#(
  parameter int DATA_WIDTH    = 1,
  parameter int ADDRESS_WIDTH = 1,
  parameter int ALMOST_FULL   = 2 ** ADDRESS_WIDTH - 1
) (
  input  logic                       aclk,
  input  logic                       areset_n,
  input  logic                       rx_tvalid,
  output logic                       rx_tready,
  input  logic [DATA_WIDTH-1:0]      rx_tdata,
  output logic                       write_enable,
  output logic [ADDRESS_WIDTH-1:0]   write_pointer,
  output logic [DATA_WIDTH-1:0]      write_data,
  input  logic                       read_enable,
  output logic                       capacity_valid,
  output logic                       almost_full,
  output logic [ADDRESS_WIDTH:0]     count
);

  localparam int CAPACITY = queue_capacity(ADDRESS_WIDTH);
  localparam int CW       = count_width(ADDRESS_WIDTH);

  typedef logic [CW-1:0] count_t;

  localparam count_t CAPACITY_C    = count_t'(CAPACITY);
  localparam count_t ALMOST_FULL_C = count_t'(ALMOST_FULL);

  count_t                     count_q, count_d;
  logic [ADDRESS_WIDTH-1:0]   write_pointer_q, write_pointer_d;
  logic                       rx_tready_q, rx_tready_d;
  logic                       capacity_valid_q, capacity_valid_d;
  logic                       almost_full_q, almost_full_d;

  assign write_enable   = rx_tvalid && rx_tready_q;
  assign write_data     = rx_tdata;
  assign rx_tready      = rx_tready_q;
  assign write_pointer  = write_pointer_q;
  assign capacity_valid = capacity_valid_q;
  assign almost_full    = almost_full_q;
  assign count          = count_q;

  // Next occupancy, pointer and registered flags; a read from an empty queue saturates at zero.
  always_comb begin
    count_d          = count_q;
    write_pointer_d  = write_pointer_q;
    rx_tready_d      = 1'b0;
    capacity_valid_d = 1'b0;
    almost_full_d    = 1'b0;

    if (read_enable && !write_enable && count_q == '0) begin
      count_d = '0;
    end else begin
      count_d = count_q + count_t'(write_enable) - count_t'(read_enable);
    end

    if (write_enable) begin
      write_pointer_d = write_pointer_q + ADDRESS_WIDTH'(1);
    end

    rx_tready_d      = (count_d < CAPACITY_C);
    capacity_valid_d = (count_d != '0);
    almost_full_d    = (count_d >= ALMOST_FULL_C);
  end

  // State register with asynchronous clear; stored entries are logically discarded on reset.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      count_q          <= '0;
      write_pointer_q  <= '0;
      rx_tready_q      <= 1'b0;
      capacity_valid_q <= 1'b0;
      almost_full_q    <= 1'b0;
    end else begin
      count_q          <= count_d;
      write_pointer_q  <= write_pointer_d;
      rx_tready_q      <= rx_tready_d;
      capacity_valid_q <= capacity_valid_d;
      almost_full_q    <= almost_full_d;
    end
  end

  // The read controller must never consume from an empty queue.
  underflow_check: assert property (@(posedge aclk) disable iff (!areset_n)
    !(read_enable && count_q == '0));

endmodule

// File: tb/tb_logic_basic_queue_generic_write.sv
// tb/tb_logic_basic_queue_generic_write.sv - table-driven bench for the queue write controller
module tb_logic_basic_queue_generic_write;

  localparam int DW = 4;
  localparam int AW = 2;
  localparam int AF = 3;

  logic          aclk = 1'b0;
  logic          areset_n;
  logic          rx_tvalid;
  logic          rx_tready;
  logic [DW-1:0] rx_tdata;
  logic          write_enable;
  logic [AW-1:0] write_pointer;
  logic [DW-1:0] write_data;
  logic          read_enable;
  logic          capacity_valid;
  logic          almost_full;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  logic_basic_queue_generic_write #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ALMOST_FULL(AF)
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata),
    .write_enable(write_enable), .write_pointer(write_pointer), .write_data(write_data),
    .read_enable(read_enable), .capacity_valid(capacity_valid),
    .almost_full(almost_full), .count(count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic          tv;
    logic [DW-1:0] td;
    logic          re;
    logic          e_tready;
    logic          e_we;
    logic [AW-1:0] e_ptr;
    logic [AW:0]   e_count;
    logic          e_cv;
    logic          e_af;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic e_tready, input logic e_we,
                           input logic [AW-1:0] e_ptr, input logic [AW:0] e_count,
                           input logic e_cv, input logic e_af);
    chk({tag, ".rx_tready"}, int'(rx_tready), int'(e_tready));
    chk({tag, ".write_enable"}, int'(write_enable), int'(e_we));
    chk({tag, ".write_pointer"}, int'(write_pointer), int'(e_ptr));
    chk({tag, ".count"}, int'(count), int'(e_count));
    chk({tag, ".capacity_valid"}, int'(capacity_valid), int'(e_cv));
    chk({tag, ".almost_full"}, int'(almost_full), int'(e_af));
  endtask

  function automatic vec_t mk(logic tv, logic [DW-1:0] td, logic re, logic tr, logic we,
                              logic [AW-1:0] p, logic [AW:0] c, logic cv, logic af);
    vec_t v;
    v.tv = tv; v.td = td; v.re = re; v.e_tready = tr; v.e_we = we;
    v.e_ptr = p; v.e_count = c; v.e_cv = cv; v.e_af = af;
    return v;
  endfunction

  initial begin
    //          tv  td    re  tr  we  ptr cnt cv  af
    vecs.push_back(mk(1, 4'hA, 0, 1, 1, 0, 0, 0, 0)); // fill
    vecs.push_back(mk(1, 4'hB, 0, 1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(1, 4'hC, 0, 1, 1, 2, 2, 1, 0));
    vecs.push_back(mk(1, 4'hD, 0, 1, 1, 3, 3, 1, 1)); // almost_full after C
    vecs.push_back(mk(1, 4'hE, 0, 0, 0, 0, 4, 1, 1)); // full, E held
    vecs.push_back(mk(1, 4'hE, 1, 0, 0, 0, 4, 1, 1)); // read at full
    vecs.push_back(mk(1, 4'hE, 0, 1, 1, 0, 3, 1, 1)); // E written at wrapped pointer 0
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 1, 4, 1, 1)); // drain
    vecs.push_back(mk(0, 4'h0, 1, 1, 0, 1, 3, 1, 1));
    vecs.push_back(mk(1, 4'h5, 1, 1, 1, 1, 2, 1, 0)); // simultaneous at count 2
    vecs.push_back(mk(0, 4'h0, 0, 1, 0, 2, 2, 1, 0)); // count unchanged, ptr advanced
    vecs.push_back(mk(0, 4'h0, 1, 1, 0, 2, 2, 1, 0));
    vecs.push_back(mk(0, 4'h0, 1, 1, 0, 2, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 1, 0, 2, 0, 0, 0)); // empty
    vecs.push_back(mk(1, 4'h7, 0, 1, 1, 2, 0, 0, 0)); // single write at empty
    vecs.push_back(mk(0, 4'h0, 0, 1, 0, 3, 1, 1, 0)); // visible one cycle later
    vecs.push_back(mk(0, 4'h0, 1, 1, 0, 3, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 1, 0, 3, 0, 0, 0)); // invisible after read

    // Reset asserted before the first clock edge clears everything asynchronously.
    areset_n = 1'b0; rx_tvalid = 1'b1; rx_tdata = 4'h0; read_enable = 1'b0;
    #2;
    chk_state("reset", 0, 0, 0, 0, 0, 0);
    @(posedge aclk); #1;
    areset_n = 1'b1; rx_tvalid = 1'b0;
    #1;
    chk_state("release", 0, 0, 0, 0, 0, 0);
    @(posedge aclk); #1;
    chk_state("ready", 1, 0, 0, 0, 0, 0);

    // Directed vector table: apply inputs, check pre-edge outputs, then clock.
    foreach (vecs[i]) begin
      rx_tvalid = vecs[i].tv; rx_tdata = vecs[i].td; read_enable = vecs[i].re;
      #1;
      chk_state($sformatf("vec%0d", i), vecs[i].e_tready, vecs[i].e_we, vecs[i].e_ptr,
                vecs[i].e_count, vecs[i].e_cv, vecs[i].e_af);
      chk($sformatf("vec%0d.write_data", i), int'(write_data), int'(vecs[i].td));
      @(posedge aclk); #1;
    end

    // Reset mid-operation: fill to 3 (pointer starts at 3 and wraps), then reset mid-clock.
    rx_tvalid = 1'b1; read_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rx_tdata = DW'(k + 1);
      @(posedge aclk); #1;
    end
    #1;
    chk_state("pre_rst", 1, 1, 2, 3, 1, 1);
    #2;
    areset_n = 1'b0;
    #1;
    chk_state("mid_rst", 0, 0, 0, 0, 0, 0);
    @(posedge aclk); #1;
    areset_n = 1'b1;
    #1;
    chk_state("mid_rel", 0, 0, 0, 0, 0, 0);
    @(posedge aclk); #1;
    rx_tdata = 4'h9;
    #1;
    chk_state("resume", 1, 1, 0, 0, 0, 0);
    @(posedge aclk); #1;
    rx_tvalid = 1'b0;
    #1;
    chk_state("resume1", 1, 0, 1, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_basic_queue_generic_write.md
Name: logic_basic_queue_generic_write

Overview:
Write-side controller of the generic queue. It is the counterpart of the queue read controller, and the two share an external dual-port memory.
- Accepts an AXI4-Stream-style input (rx_tvalid/rx_tready/rx_tdata) and drives the memory write port (write_enable, write_pointer, write_data).
- Owns the occupancy counter. Produces capacity_valid for the read controller, which returns read_enable to this block.
- Provides full/almost_full status.

Parameters:
DATA_WIDTH, 1, width of stream data and memory word.
ADDRESS_WIDTH, 1, memory address width; CAPACITY = 2**ADDRESS_WIDTH entries.
ALMOST_FULL, 2**ADDRESS_WIDTH - 1, occupancy threshold for almost_full; legal range 1..CAPACITY.

Ports:
aclk  input  1  clock, all logic on rising edge.
areset_n  input  1  asynchronous active-low reset.
rx_tvalid  input  1  input beat valid.
rx_tready  output  1  block can accept a beat.
rx_tdata  input  DATA_WIDTH  input beat data.
write_enable  output  1  memory write strobe.
write_pointer  output  ADDRESS_WIDTH  memory write address.
write_data  output  DATA_WIDTH  memory write data.
read_enable  input  1  entry consumed by the read controller this cycle.
capacity_valid  output  1  queue holds at least one committed entry.
almost_full  output  1  occupancy >= ALMOST_FULL.
count  output  ADDRESS_WIDTH+1  current occupancy, 0..CAPACITY.

Behaviour:
- Clock and reset: clock aclk; reset areset_n, asynchronous, active-low. All registers clear asynchronously on reset.
- Reset values: rx_tready=0, capacity_valid=0, almost_full=0, count=0, write_pointer=0. write_enable is combinational and is 0 because rx_tready=0.
- Handshake:
  - write_enable = rx_tvalid && rx_tready (combinational).
  - write_data = rx_tdata (combinational pass-through). There is no latency between the accepted beat and the memory write.
  - rx_tdata is ignored when write_enable=0.
- Write pointer: increments by 1 on each write_enable. Wraps modulo CAPACITY (CAPACITY-1 -> 0) with no special handling.
- Occupancy:
  - count_next = count + write_enable - read_enable, computed at ADDRESS_WIDTH+1 bits.
  - Simultaneous write and read: count unchanged.
  - read_enable with count==0 is a protocol violation. count saturates at 0, and an assertion must fire in simulation.
  - write_enable with count==CAPACITY is impossible by construction.
- Registered flags, updated every cycle from count_next, so there is no combinational path from read_enable or rx_tvalid to any output except write_enable:
  - rx_tready <= (count_next < CAPACITY).
  - capacity_valid <= (count_next != 0). A written entry becomes visible to the reader one cycle after the write, which matches the synchronous memory write.
  - almost_full <= (count_next >= ALMOST_FULL).
- Full boundary: the beat that brings count to CAPACITY is accepted. rx_tready drops the next cycle. It re-asserts the cycle after the first read_enable at full.
- First cycle after reset release: rx_tready rises to 1; no beat is accepted during the reset-release cycle.
- Reset mid-operation: stored data is discarded logically (count=0, pointer=0). The memory contents are don't-care.
- Unused rx_tvalid while rx_tready=0 has no effect. The upstream source holds rx_tdata stable, per the stream protocol.

Decomposition:
- Shared package logic_basic_queue_pkg:
  - count_t typedef (ADDRESS_WIDTH+1 bits, parameterised via function/localparam pattern).
  - CAPACITY computation function.
  - Helpers shared with the read controller.
- No sub-module. The counter and flags are ~150 lines inline.
- The top-level queue wrapper instantiates this block, the read controller and the memory.

Test Plan:
All scenarios use ADDRESS_WIDTH=2 (CAPACITY=4) and ALMOST_FULL=3.
1. Reset: assert areset_n=0 mid-clock -> all outputs 0 immediately. Release -> rx_tready=1 one cycle later, count=0.
2. Fill: rx_tvalid=1 with data 0xA,0xB,0xC,0xD,0xE, read_enable=0.
   - Writes occur at pointers 0,1,2,3, then the pointer wraps to 0.
   - count=4 and rx_tready=0 the cycle after 0xD is accepted; 0xE is held with write_enable=0.
   - almost_full=1 the cycle after 0xC is accepted.
3. Drain at full: single-cycle read_enable pulse at count=4 -> count=3 and rx_tready=1 next cycle. 0xE is then written at pointer 0.
4. Simultaneous: at count=2, write_enable and read_enable in the same cycle -> count stays 2, write_pointer advances by 1, capacity_valid stays 1.
5. Empty visibility: write one beat at count=0 -> capacity_valid=1 exactly one cycle later. read_enable then drops count to 0, and capacity_valid=0 next cycle.
6. Reset mid-operation: at count=3 with rx_tvalid=1, assert areset_n=0 -> count=0, write_pointer=0, rx_tready=0, capacity_valid=0 asynchronously. Normal fill resumes after release.
